// File: rtl/text_pkg.sv
// Shared types and constants for the text-mode renderer: VRAM cell layout,
// 12-bit palette colours and the palette power-on contents.
package text_pkg;

    localparam int GLYPH_W   = 8;
    localparam int PAL_DEPTH = 16;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t PAL_RESET_FG = 12'hFFF;
    localparam rgb12_t PAL_RESET_BG = 12'h000;

    // One 16-bit character cell as stored in VRAM.
    typedef struct packed {
        logic       inv;
        logic [6:0] glyph;
        logic [3:0] fg;
        logic [3:0] bg;
    } cell_t;

    // Entry 0 is the blank/background colour; every other entry starts white.
    function automatic rgb12_t pal_reset_value(input int idx);
        return (idx == 0) ? PAL_RESET_BG : PAL_RESET_FG;
    endfunction

endpackage

// File: rtl/text_palette.sv
// 16-entry x 12-bit CPU-writable palette. The read port is combinational and
// has no write bypass: a same-cycle read of the entry being written sees the old value.
module text_palette
    import text_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  rgb12_t     wdata,
    input  logic [3:0] raddr,
    output rgb12_t     rdata
);

    rgb12_t pal_reg [PAL_DEPTH];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                pal_reg[i] <= pal_reset_value(i);
            end
        end else if (we) begin
            pal_reg[waddr] <= wdata;
        end
    end

    assign rdata = pal_reg[raddr];

endmodule

// File: rtl/text_render_pipe.sv
// Three-stage text-mode renderer: scan position -> VRAM word -> font line ->
// palette colour, with a blinking underline cursor and syncs delayed to match.
module text_render_pipe
    import text_pkg::*;
#(
    parameter int COLS           = 80,
    parameter int ROWS           = 30,
    parameter int GLYPH_H        = 16,
    parameter int CHARS_PER_WORD = 2,
    parameter int CURSOR_START   = 14,
    parameter int BLINK_SHIFT    = 4,
    localparam int ADDR_W  = $clog2(COLS * ROWS / CHARS_PER_WORD),
    localparam int FONT_AW = $clog2(128 * GLYPH_H),
    localparam int COL_W   = $clog2(COLS),
    localparam int ROW_W   = $clog2(ROWS)
) (
    input  logic                          pixel_clk,
    input  logic                          reset,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          vde_in,
    input  logic                          hs_in,
    input  logic                          vs_in,
    output logic [ADDR_W-1:0]             vram_addr,
    input  logic [16*CHARS_PER_WORD-1:0]  vram_rdata,
    output logic [FONT_AW-1:0]            font_addr,
    input  logic [7:0]                    font_data,
    input  logic                          pal_we,
    input  logic [3:0]                    pal_waddr,
    input  logic [11:0]                   pal_wdata,
    input  logic                          cursor_en,
    input  logic [COL_W-1:0]              cursor_col,
    input  logic [ROW_W-1:0]              cursor_row,
    output logic [3:0]                    Red,
    output logic [3:0]                    Green,
    output logic [3:0]                    Blue,
    output logic                          vde_out,
    output logic                          hs_out,
    output logic                          vs_out
);

    localparam int LINE_W        = $clog2(GLYPH_H);
    localparam int XCOL_W        = 10 - $clog2(GLYPH_W);
    localparam int YROW_W        = 10 - LINE_W;
    localparam int SLOT_W        = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
    localparam int WORDS_PER_ROW = COLS / CHARS_PER_WORD;

    // ---------------- scan position decode (combinational) ----------------
    logic [XCOL_W-1:0] col_now;
    logic [YROW_W-1:0] row_now;
    logic [LINE_W-1:0] line_now;
    logic              in_range;

    assign col_now  = DrawX[9:3];
    assign row_now  = DrawY[9:LINE_W];
    assign line_now = DrawY[LINE_W-1:0];
    assign in_range = (int'(col_now) < COLS) && (int'(row_now) < ROWS);

    // Off-screen positions park the address at 0 so the BRAM never sees an out-of-range index.
    assign vram_addr = in_range
        ? ADDR_W'(row_now * WORDS_PER_ROW + col_now / CHARS_PER_WORD)
        : '0;

    // ---------------- stage 1: position registers ----------------
    logic [XCOL_W-1:0] s1_col_reg;
    logic [YROW_W-1:0] s1_row_reg;
    logic [LINE_W-1:0] s1_line_reg;
    logic [2:0]        s1_px_reg;
    logic [SLOT_W-1:0] s1_slot_reg;
    logic              s1_valid_reg;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s1_col_reg   <= '0;
            s1_row_reg   <= '0;
            s1_line_reg  <= '0;
            s1_px_reg    <= '0;
            s1_slot_reg  <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_col_reg   <= col_now;
            s1_row_reg   <= row_now;
            s1_line_reg  <= line_now;
            s1_px_reg    <= DrawX[2:0];
            s1_slot_reg  <= SLOT_W'(int'(col_now) % CHARS_PER_WORD);
            s1_valid_reg <= in_range;
        end
    end

    // Split the VRAM word into its packed cells; slot k lives at bits [16k+15:16k].
    cell_t word_cells [CHARS_PER_WORD];

    generate
        for (genvar gi = 0; gi < CHARS_PER_WORD; gi++) begin : g_slot
            assign word_cells[gi] = cell_t'(vram_rdata[16*gi +: 16]);
        end
    endgenerate

    cell_t s1_cell;
    logic  s1_cursor_hit;

    assign s1_cell       = word_cells[s1_slot_reg];
    assign font_addr     = FONT_AW'({s1_cell.glyph, s1_line_reg});
    assign s1_cursor_hit = cursor_en
                        && (32'(s1_col_reg) == 32'(cursor_col))
                        && (32'(s1_row_reg) == 32'(cursor_row));

    // ---------------- stage 2: cell + font line ----------------
    cell_t             s2_cell_reg;
    logic [LINE_W-1:0] s2_line_reg;
    logic [2:0]        s2_px_reg;
    logic              s2_cursor_reg;
    logic              s2_valid_reg;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s2_cell_reg   <= '0;
            s2_line_reg   <= '0;
            s2_px_reg     <= '0;
            s2_cursor_reg <= 1'b0;
            s2_valid_reg  <= 1'b0;
        end else begin
            s2_cell_reg   <= s1_cell;
            s2_line_reg   <= s1_line_reg;
            s2_px_reg     <= s1_px_reg;
            s2_cursor_reg <= s1_cursor_hit;
            s2_valid_reg  <= s1_valid_reg;
        end
    end

    logic [BLINK_SHIFT:0] frame_cnt_reg;
    logic [BLINK_SHIFT:0] frame_cnt_next;
    logic                 blink_phase;
    logic                 font_bit;
    logic                 cursor_flip;
    logic                 pix_bit;
    logic [3:0]           pal_idx;
    rgb12_t               pal_rdata;

    assign blink_phase = frame_cnt_reg[BLINK_SHIFT];

    always_comb begin
        font_bit    = font_data[3'(GLYPH_W - 1) - s2_px_reg] ^ s2_cell_reg.inv;
        // Only the underline rows of the cursor cell blink; the glyph itself never does.
        cursor_flip = s2_cursor_reg && (32'(s2_line_reg) >= CURSOR_START) && blink_phase;
        pix_bit     = font_bit ^ cursor_flip;
        pal_idx     = 4'd0;
        if (s2_valid_reg) begin
            pal_idx = pix_bit ? s2_cell_reg.fg : s2_cell_reg.bg;
        end
    end

    text_palette u_palette (
        .clk   (pixel_clk),
        .srst  (reset),
        .we    (pal_we),
        .waddr (pal_waddr),
        .wdata (pal_wdata),
        .raddr (pal_idx),
        .rdata (pal_rdata)
    );

    // ---------------- sync delay line and blink counter ----------------
    logic [2:0] vde_sr_reg;
    logic [2:0] hs_sr_reg;
    logic [2:0] vs_sr_reg;
    logic       vs_fall;

    // vs_sr_reg[0] doubles as the previous vs_in sample for edge detection.
    assign vs_fall = vs_sr_reg[0] & ~vs_in;

    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        if (vs_fall) begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            vde_sr_reg    <= 3'b000;
            hs_sr_reg     <= 3'b111;
            vs_sr_reg     <= 3'b111;
            frame_cnt_reg <= '0;
        end else begin
            vde_sr_reg    <= {vde_sr_reg[1:0], vde_in};
            hs_sr_reg     <= {hs_sr_reg[1:0], hs_in};
            vs_sr_reg     <= {vs_sr_reg[1:0], vs_in};
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // ---------------- stage 3: output colour ----------------
    rgb12_t rgb_reg;

    // vde_sr_reg[1] is the active-video flag of the pixel being captured here.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rgb_reg <= '0;
        end else begin
            rgb_reg <= vde_sr_reg[1] ? pal_rdata : 12'h000;
        end
    end

    assign Red     = rgb_reg[11:8];
    assign Green   = rgb_reg[7:4];
    assign Blue    = rgb_reg[3:0];
    assign vde_out = vde_sr_reg[2];
    assign hs_out  = hs_sr_reg[2];
    assign vs_out  = vs_sr_reg[2];

endmodule
